// File: rtl/mcu_ctrl.sv
// Purpose: multicycle control FSM for a small MIPS-like core (FETCH/DECODE/EXE/MEM/WB).
// Latency: j/NOP 2, beq 3, ALU ops 4, sw 3+N, lw 4+N cycles (N = MEM cycles).
// Backpressure: the FSM stalls in MEM until mem_ready is sampled high.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   op, funct           - IR fields [31:26] and [5:0], stable from DECODE to retire
//   zero, mem_ready     - ALU equality flag, data memory completion
//   pc_wr, pc_src       - PC load enable and source (0 PC+4, 1 branch, 2 jump)
//   ir_wr, reg_wr       - IR load, register file write
//   reg_dst, wd_sel     - write address (rt/rd), write data (ALU/memory)
//   alu_src_b, alu_op   - ALU B operand select, ALU operation
//   EOp                 - extender mode
//   mem_rd, mem_wr      - memory read/write requests
//   state, retire_cnt   - current FSM state, retired-instruction counter
module mcu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        ir_wr,
  output logic        reg_wr,
  output logic        reg_dst,
  output logic        wd_sel,
  output logic        alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  EOp,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  state,
  output logic [31:0] retire_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUBU   = 6'b100011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  localparam logic [1:0] E_SIGN  = 2'b00;
  localparam logic [1:0] E_ZERO  = 2'b01;
  localparam logic [1:0] E_UPPER = 2'b10;
  localparam logic [1:0] E_SHL2  = 2'b11;

  logic [2:0]  r_state;
  logic [31:0] r_retire_cnt;
  logic [2:0]  w_next_state;
  logic        w_retire;

  logic w_addu, w_subu, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_nop;
  logic w_ls;

  // EXE operand/operation selection, reused unchanged through MEM
  logic [2:0] w_alu_op;
  logic       w_alu_src_b;
  logic [1:0] w_eop;

  // Un-gated control values; write strobes are masked by reset below
  logic       w_pc_wr, w_ir_wr, w_reg_wr, w_mem_rd, w_mem_wr;
  logic [1:0] w_pc_src;
  logic       w_reg_dst, w_wd_sel;

  assign w_addu = (op == OP_RTYPE) && (funct == F_ADDU);
  assign w_subu = (op == OP_RTYPE) && (funct == F_SUBU);
  assign w_ori  = (op == OP_ORI);
  assign w_lw   = (op == OP_LW);
  assign w_sw   = (op == OP_SW);
  assign w_beq  = (op == OP_BEQ);
  assign w_lui  = (op == OP_LUI);
  assign w_j    = (op == OP_J);
  assign w_nop  = !(w_addu || w_subu || w_ori || w_lw || w_sw || w_beq || w_lui || w_j);
  assign w_ls   = w_lw || w_sw;

  // Next state and retire strobe. Any encoding that cannot legally occur
  // (unused state, or an instruction type that should not reach a state)
  // falls back to FETCH without counting a retirement.
  always_comb begin
    w_next_state = S_FETCH;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_j || w_nop) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else begin
          w_next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (w_beq) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else if (w_ls) begin
          w_next_state = S_MEM;
        end else if (w_addu || w_subu || w_ori || w_lui) begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        if (!w_ls) begin
          w_next_state = S_FETCH;
        end else if (!mem_ready) begin
          w_next_state = S_MEM;
        end else if (w_lw) begin
          w_next_state = S_WB;
        end else begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_WB: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_retire_cnt <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;  // wraps naturally at 2^32
      end
    end
  end

  always_comb begin
    w_alu_op    = ALU_ADD;
    w_alu_src_b = 1'b0;
    w_eop       = E_SIGN;
    if (w_subu) begin
      w_alu_op = ALU_SUB;
    end else if (w_ori) begin
      w_alu_op    = ALU_OR;
      w_alu_src_b = 1'b1;
      w_eop       = E_ZERO;
    end else if (w_lui) begin
      w_alu_op    = ALU_OR;
      w_alu_src_b = 1'b1;
      w_eop       = E_UPPER;
    end else if (w_ls) begin
      w_alu_src_b = 1'b1;
    end else if (w_beq) begin
      w_alu_op = ALU_SUB;
      w_eop    = E_SHL2;
    end
  end

  always_comb begin
    w_pc_wr   = 1'b0;
    w_pc_src  = 2'd0;
    w_ir_wr   = 1'b0;
    w_reg_wr  = 1'b0;
    w_reg_dst = 1'b0;
    w_wd_sel  = 1'b0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    EOp       = E_SIGN;
    case (r_state)
      S_FETCH: begin
        w_ir_wr = 1'b1;
        w_pc_wr = 1'b1;
      end
      S_DECODE: begin
        if (w_j) begin
          w_pc_wr  = 1'b1;
          w_pc_src = 2'd2;
        end
      end
      S_EXE: begin
        if (!(w_j || w_nop)) begin
          alu_op    = w_alu_op;
          alu_src_b = w_alu_src_b;
          EOp       = w_eop;
        end
        if (w_beq) begin
          w_pc_wr  = zero;
          w_pc_src = 2'd1;
        end
      end
      S_MEM: begin
        if (w_ls) begin
          alu_op    = w_alu_op;
          alu_src_b = w_alu_src_b;
          EOp       = w_eop;
        end
        w_mem_rd = w_lw;
        w_mem_wr = w_sw;
      end
      S_WB: begin
        w_reg_wr  = 1'b1;
        w_reg_dst = w_addu || w_subu;
        w_wd_sel  = w_lw;
      end
      default: ;
    endcase
  end

  // Side-effecting strobes are suppressed for as long as reset is held,
  // including the cycle in which reset interrupts a memory wait.
  assign pc_wr      = w_pc_wr  && !reset;
  assign ir_wr      = w_ir_wr  && !reset;
  assign reg_wr     = w_reg_wr && !reset;
  assign mem_rd     = w_mem_rd && !reset;
  assign mem_wr     = w_mem_wr && !reset;
  assign pc_src     = w_pc_src;
  assign reg_dst    = w_reg_dst;
  assign wd_sel     = w_wd_sel;
  assign state      = r_state;
  assign retire_cnt = r_retire_cnt;

endmodule
